// File: rtl/sliding_window_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sliding_window_pkg
// Purpose  : Shared helpers and types for the sliding_window stage.
// Revision : 1.0 - initial release
// ============================================================================
package sliding_window_pkg;

    localparam int DEFAULT_NUMBERS_AMOUNT = 10;
    localparam int DEFAULT_NUMBER_WIDTH   = 10;

    // Window vector in the default configuration; index 0 is the oldest sample.
    typedef logic [DEFAULT_NUMBERS_AMOUNT-1:0][DEFAULT_NUMBER_WIDTH-1:0] window_t;

    function automatic int cnt_width(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage : sliding_window_pkg
`default_nettype wire

// File: rtl/sliding_window_if.sv
`default_nettype none
// ============================================================================
// Module   : sliding_window_if
// Purpose  : Sample-in / window-out handshake bundle of sliding_window.
//            SLIDING_WINDOW_LAST_EN adds last_i / last_o.
// Revision : 1.0 - initial release
// ============================================================================
interface sliding_window_if #(
    parameter int NUMBERS_AMOUNT = 10,
    parameter int NUMBER_WIDTH   = 10
);
    logic [NUMBER_WIDTH-1:0]                     data_i;
    logic                                        data_valid_i;
    logic                                        ready_o;
    logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] data_o;
    logic                                        data_valid_o;
    logic                                        ready_i;
`ifdef SLIDING_WINDOW_LAST_EN
    logic                                        last_i;
    logic                                        last_o;

    modport master (output data_i, data_valid_i, last_i, ready_i,
                    input  ready_o, data_o, data_valid_o, last_o);
    modport slave  (input  data_i, data_valid_i, last_i, ready_i,
                    output ready_o, data_o, data_valid_o, last_o);
`else
    modport master (output data_i, data_valid_i, ready_i,
                    input  ready_o, data_o, data_valid_o);
    modport slave  (input  data_i, data_valid_i, ready_i,
                    output ready_o, data_o, data_valid_o);
`endif
endinterface : sliding_window_if
`default_nettype wire

// File: rtl/sliding_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sliding_window_ctrl
// Purpose  : Fill/stride counting, emit decision and output-valid register.
//            SLIDING_WINDOW_LAST_EN adds last_i / last_o handling.
// Revision : 1.0 - initial release
// ============================================================================
module sliding_window_ctrl
    import sliding_window_pkg::*;
#(
    parameter int NUMBERS_AMOUNT = 10,
    parameter int STRIDE         = 1
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic accept_i,
`ifdef SLIDING_WINDOW_LAST_EN
    input  wire logic last_i,
    output logic      last_o,
`endif
    input  wire logic ready_i,
    output logic      data_valid_o
);
    localparam int C_FILL_W   = cnt_width(NUMBERS_AMOUNT + 1);
    localparam int C_STRIDE_W = cnt_width(STRIDE);
    localparam logic [C_FILL_W-1:0]   C_FILL_FULL   = C_FILL_W'(NUMBERS_AMOUNT);
    localparam logic [C_STRIDE_W-1:0] C_STRIDE_LAST = C_STRIDE_W'(STRIDE - 1);

    logic [C_FILL_W-1:0]   fill_q,   fill_d;
    logic [C_STRIDE_W-1:0] stride_q, stride_d;
    logic                  valid_q,  valid_d;
    logic                  emit;
    logic                  hold;

    always_comb begin
        fill_d   = fill_q;
        stride_d = stride_q;
        emit     = 1'b0;
        hold     = valid_q && !ready_i;
        if (accept_i) begin
            // Stride only advances once the window was already full before this sample.
            if (fill_q == C_FILL_FULL) begin
                stride_d = (stride_q == C_STRIDE_LAST) ? '0 : stride_q + 1'b1;
                emit     = (stride_d == '0);
            end else begin
                fill_d = fill_q + 1'b1;
                emit   = (fill_d == C_FILL_FULL);
            end
`ifdef SLIDING_WINDOW_LAST_EN
            if (last_i) begin
                fill_d   = '0;
                stride_d = '0;
            end
`endif
        end
        valid_d = emit || hold;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_q   <= '0;
            stride_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            fill_q   <= fill_d;
            stride_q <= stride_d;
            valid_q  <= valid_d;
        end
    end

    assign data_valid_o = valid_q;

`ifdef SLIDING_WINDOW_LAST_EN
    logic last_q, last_d;

    always_comb begin
        last_d = 1'b0;
        if (emit) begin
            last_d = last_i;
        end else if (hold) begin
            last_d = last_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;
`endif

endmodule : sliding_window_ctrl
`default_nettype wire

// File: rtl/sliding_window.sv
`default_nettype none
// ============================================================================
// Module   : sliding_window
// Purpose  : Keeps the last NUMBERS_AMOUNT samples and emits them as a packed
//            window every STRIDE accepts. SLIDING_WINDOW_LAST_EN adds last tags.
// Revision : 1.0 - initial release
// ============================================================================
module sliding_window
    import sliding_window_pkg::*;
#(
    parameter int NUMBERS_AMOUNT = 10,
    parameter int NUMBER_WIDTH   = 10,
    parameter int STRIDE         = 1
) (
    input wire logic         clk_i,
    input wire logic         rst_i,
    sliding_window_if.slave  bus
);
    typedef logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] win_vec_t;

    win_vec_t window_q, window_d;
    logic     data_valid;
    logic     ready;
    logic     accept;

    // No skid buffer: a sample is taken only when the output slot frees this edge.
    assign ready         = !data_valid || bus.ready_i;
    assign accept        = bus.data_valid_i && ready;
    assign bus.ready_o      = ready;
    assign bus.data_valid_o = data_valid;
    assign bus.data_o       = window_q;

    always_comb begin
        window_d = window_q;
        if (accept) begin
            for (int k = 0; k < NUMBERS_AMOUNT - 1; k++) begin
                window_d[k] = window_q[k+1];
            end
            window_d[NUMBERS_AMOUNT-1] = bus.data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            window_q <= '0;
        end else begin
            window_q <= window_d;
        end
    end

    sliding_window_ctrl #(
        .NUMBERS_AMOUNT (NUMBERS_AMOUNT),
        .STRIDE         (STRIDE)
    ) u_ctrl (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .accept_i     (accept),
`ifdef SLIDING_WINDOW_LAST_EN
        .last_i       (bus.last_i),
        .last_o       (bus.last_o),
`endif
        .ready_i      (bus.ready_i),
        .data_valid_o (data_valid)
    );

endmodule : sliding_window
`default_nettype wire
